sign_mag_bcd_conv: RTL and testbench

//  Downstream stage of the sign-magnitude adder. Takes one N-bit sign-magnitude

---
 rtl/sign_mag_bcd_conv_if.sv | 24 ++
 rtl/sign_mag_bcd_conv.sv | 106 ++++++++++
 tb/tb_sign_mag_bcd_conv.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sign_mag_bcd_conv_if.sv
// Request/response bundle between a sign-magnitude producer and the BCD converter.
// The producer drives start/sm_in; the converter returns handshake status and digits.
interface sign_mag_bcd_conv_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] sm_in;
   logic         ready;
   logic         done_tick;
   logic         neg;
   logic [3:0]   bcd2;
   logic [3:0]   bcd1;
   logic [3:0]   bcd0;

   modport master (
      output start, sm_in,
      input  ready, done_tick, neg, bcd2, bcd1, bcd0
   );

   modport slave (
      input  start, sm_in,
      output ready, done_tick, neg, bcd2, bcd1, bcd0
   );
endinterface

// File: rtl/sign_mag_bcd_conv.sv
// Sign-magnitude to sign + 3-digit BCD converter.
// Uses sequential double dabble, one magnitude bit per clock.
module sign_mag_bcd_conv #(
   parameter int N = 8
) (
   input logic               clk,
   input logic               reset,
   sign_mag_bcd_conv_if.slave bus
);

   typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

   state_t         state_q, state_d;
   logic [N-2:0]   mag_q;
   logic           sgn_q;
   logic           nz_q;
   logic [3:0]     d2_q, d1_q, d0_q;
   logic [3:0]     cnt_q;
   logic           neg_q;
   logic [3:0]     bcd2_q, bcd1_q, bcd0_q;

   logic [N+10:0]  sh;
   logic [3:0]     nd2, nd1, nd0;
   logic [N-2:0]   nmag;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // Adjust every digit first so none exceeds 9 after the shift.
   always_comb begin
      sh   = {add3(d2_q), add3(d1_q), add3(d0_q), mag_q} << 1;
      nd2  = sh[N+10 -: 4];
      nd1  = sh[N+6  -: 4];
      nd0  = sh[N+2  -: 4];
      nmag = sh[N-2:0];
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = OP;
         OP:      if (cnt_q == 4'd1) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mag_q  <= '0;
         sgn_q  <= 1'b0;
         nz_q   <= 1'b0;
         d2_q   <= '0;
         d1_q   <= '0;
         d0_q   <= '0;
         cnt_q  <= '0;
         neg_q  <= 1'b0;
         bcd2_q <= '0;
         bcd1_q <= '0;
         bcd0_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  mag_q <= bus.sm_in[N-2:0];
                  sgn_q <= bus.sm_in[N-1];
                  nz_q  <= |bus.sm_in[N-2:0];
                  d2_q  <= '0;
                  d1_q  <= '0;
                  d0_q  <= '0;
                  cnt_q <= 4'(N-1);
               end
            end
            OP: begin
               d2_q  <= nd2;
               d1_q  <= nd1;
               d0_q  <= nd0;
               mag_q <= nmag;
               cnt_q <= cnt_q - 4'd1;
               // Final shift: publish digits; a zero magnitude never reports negative.
               if (cnt_q == 4'd1) begin
                  neg_q  <= sgn_q & nz_q;
                  bcd2_q <= nd2;
                  bcd1_q <= nd1;
                  bcd0_q <= nd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready     = (state_q == IDLE);
   assign bus.done_tick = (state_q == DONE);
   assign bus.neg       = neg_q;
   assign bus.bcd2      = bcd2_q;
   assign bus.bcd1      = bcd1_q;
   assign bus.bcd0      = bcd0_q;

endmodule

// File: tb/tb_sign_mag_bcd_conv.sv
// Self-checking bench for sign_mag_bcd_conv: directed and random conversions
// at N=8 and N=10 against a decimal-arithmetic reference model.
module tb_sign_mag_bcd_conv;

   logic clk = 1'b0;
   logic reset;

   sign_mag_bcd_conv_if #(.N(8))  b8();
   sign_mag_bcd_conv_if #(.N(10)) b10();

   sign_mag_bcd_conv #(.N(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));
   sign_mag_bcd_conv #(.N(10)) dut10 (.clk(clk), .reset(reset), .bus(b10.slave));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [12:0] prev8  = '0;
   logic [12:0] prev10 = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {neg, hundreds, tens, units} from plain decimal arithmetic.
   function automatic logic [12:0] model(input int unsigned v, input int n);
      int unsigned mag;
      logic s;
      mag = v & ((32'd1 << (n-1)) - 1);
      s   = ((v >> (n-1)) & 1) != 0;
      return {s && (mag != 0), 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
   endfunction

   function automatic logic [12:0] out8();
      return {b8.neg, b8.bcd2, b8.bcd1, b8.bcd0};
   endfunction

   function automatic logic [12:0] out10();
      return {b10.neg, b10.bcd2, b10.bcd1, b10.bcd0};
   endfunction

   // Called from a negedge with the DUT idle; returns at the negedge of cycle N+1.
   task automatic run8(input logic [7:0] v, input bit hold);
      logic [12:0] exp;
      int cyc;
      exp = model(v, 8);
      check("rdy_idle8", b8.ready, 1);
      b8.start = 1'b1;
      b8.sm_in = v;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (hold) b8.sm_in = 8'($urandom);
         else      b8.start = 1'b0;
         @(negedge clk);
         if (!b8.done_tick) check("hold8", out8(), prev8);
      end while (!b8.done_tick && cyc < 20);
      check("latency8", cyc, 8);
      check("result8", out8(), exp);
      @(posedge clk); #1;
      b8.start = 1'b0;
      @(negedge clk);
      check("rdy_after8", b8.ready, 1);
      check("one_tick8", b8.done_tick, 0);
      check("keep8", out8(), exp);
      prev8 = exp;
   endtask

   task automatic run10(input logic [9:0] v);
      logic [12:0] exp;
      int cyc;
      exp = model(v, 10);
      check("rdy_idle10", b10.ready, 1);
      b10.start = 1'b1;
      b10.sm_in = v;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         b10.start = 1'b0;
         @(negedge clk);
         if (!b10.done_tick) check("hold10", out10(), prev10);
      end while (!b10.done_tick && cyc < 20);
      check("latency10", cyc, 10);
      check("result10", out10(), exp);
      @(negedge clk);
      check("rdy_after10", b10.ready, 1);
      check("one_tick10", b10.done_tick, 0);
      prev10 = exp;
   endtask

   initial begin
      reset     = 1'b1;
      b8.start  = 1'b0;
      b8.sm_in  = '0;
      b10.start = 1'b0;
      b10.sm_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready8", b8.ready, 1);
      check("rst_tick8", b8.done_tick, 0);
      check("rst_out8", out8(), 0);
      check("rst_ready10", b10.ready, 1);
      check("rst_out10", out10(), 0);
      reset = 1'b0;
      @(negedge clk);

      run8(8'h85, 0);
      run8(8'h7F, 0);
      run8(8'hFF, 0);
      run8(8'h80, 0);
      run8(8'h00, 0);
      run8(8'h2A, 1);
      for (int i = 0; i < 30; i++) run8(8'($urandom), ($urandom_range(0, 1) == 1));

      // Abort mid-conversion: accept 0x63, assert reset in cycle 4.
      b8.start = 1'b1;
      b8.sm_in = 8'h63;
      repeat (4) begin
         @(posedge clk); #1;
         b8.start = 1'b0;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready", b8.ready, 1);
      check("abort_tick", b8.done_tick, 0);
      check("abort_out", out8(), 0);
      prev8 = '0;
      repeat (12) begin
         @(negedge clk);
         check("abort_no_tick", b8.done_tick, 0);
      end

      // Reset and start together: the start is lost.
      b8.start = 1'b1;
      b8.sm_in = 8'h05;
      reset    = 1'b1;
      @(posedge clk); #1;
      reset    = 1'b0;
      b8.start = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("rs_no_tick", b8.done_tick, 0);
      end
      check("rs_ready", b8.ready, 1);
      check("rs_out", out8(), 0);

      run8(8'h63, 0);
      check("fresh_63", out8(), 13'h0099);

      prev10 = '0;
      run10(10'h1FF);
      check("n10_511", out10(), 13'h0511);
      run10(10'h200);
      run10(10'h3FF);
      for (int i = 0; i < 10; i++) run10(10'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
